uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial UART receiver: deserialises one asynchronous frame (start, BIT_LENGHT data bits LSB first,
//  optional parity, STOP_BITS stop bits) from iRx into a parallel word with a one-cycle valid strobe.
//  It is the receive end of the team's uart_tx link and shares its framing parameters.
//  Uses 16x oversampling with mid-bit sampling; drives keyboard/host command logic.
// PARAMETERS
//  CLK_FREQ     50_000_000  system clock frequency in Hz
//  BAUD_RATE    9600        line bit rate
//  BIT_LENGHT   8           data bits per frame (5..9)
//  PARITY_TYPE  0           0 = none, 1 = odd, 2 = even (parity bit = ~^data for odd, ^data for even)
//  STOP_BITS    1           stop bits checked per frame (1..2)
// PORTS
//  iClk         in   1           system clock, all logic on rising edge
//  iRst         in   1           asynchronous reset, active-low
//  iRx          in   1           serial line, idle high, asynchronous to iClk
//  oData_rx     out  BIT_LENGHT  last received word, held until next frame completes
//  oValid_rx    out  1           one-cycle pulse: oData_rx and error flags updated
//  oBusy_rx     out  1           high from start-edge detection until return to IDLE
//  oParity_err  out  1           parity mismatch in last frame (0 when PARITY_TYPE = 0)
//  oFrame_err   out  1           a stop-bit sample was 0 in last frame
// BEHAVIOUR
//  Reset: all outputs 0, oData_rx = 0, FSM = IDLE, synchroniser flops = 1, all counters 0.
//  iRx passes through a 2-flop synchroniser (rx_s); only rx_s is used by the FSM.
//  Tick: DIV = CLK_FREQ/(BAUD_RATE*16) (integer, truncated); divider counter pulses os_tick every DIV clocks.
//   Divider cleared on start-edge detection so the sample phase aligns to the frame.
//  Sample counter (4 bit) counts os_ticks; a bit is sampled when it reaches 7 (mid-bit) in START,
//   and at every wrap 15->0 thereafter (16 ticks apart).
//  FSM states IDLE, START, DATA, PARITY, STOP:
//   IDLE:   rx_s == 0 -> START, oBusy_rx = 1, clear divider/sample/bit counters.
//   START:  at mid-bit: rx_s == 0 -> DATA; rx_s == 1 -> false start, IDLE, oBusy_rx = 0, no valid pulse.
//   DATA:   each bit sample shifts rx_s into shift reg MSB side (LSB-first line order);
//           after BIT_LENGHT samples -> PARITY if PARITY_TYPE != 0, else STOP.
//   PARITY: one sample; perr = (rx_s != expected parity of shift reg) -> STOP.
//   STOP:   STOP_BITS samples; any sample 0 sets ferr. After the last stop sample -> IDLE.
//  Completion: in the clock after the last stop-bit sample: oData_rx <= shift reg,
//   oParity_err <= perr, oFrame_err <= ferr, oValid_rx = 1 for exactly one clock, oBusy_rx = 0.
//  oValid_rx pulses even on errors; flags hold until next completion (not sticky across frames).
//  Return to IDLE at mid stop bit: a start edge directly after the stop bit (back-to-back frames)
//   is detected with no lost frame.
//  Line held low (break): frame completes with oFrame_err = 1; IDLE re-arms only after rx_s seen high
//   (no re-trigger on a continuous low).
//  Reset asserted mid-frame: immediate return to reset values; partial frame discarded, no valid pulse.
//  Bit counter 4 bit, stop counter 2 bit; no counter wraps within a legal frame.
// TESTING (CLK_FREQ 50 MHz, BAUD_RATE 9600, DIV = 325, bit period = 5200 clocks)
//  1. PARITY 0, send 0xA5 -> oData_rx = 0xA5, oValid_rx high 1 clock, both error flags 0, oBusy_rx low after.
//  2. PARITY 2, send 0x07 with parity 1 -> no error; resend with parity 0 -> oData_rx = 0x07, oParity_err = 1.
//  3. iRx low for 4 os_tick periods (~1300 clocks) then high -> no oValid_rx, oBusy_rx returns 0 in START.
//  4. Send 0x3C with stop bit forced 0 -> oData_rx = 0x3C, oFrame_err = 1; then line high, 0x11 -> flags 0.
//  5. Back-to-back 0x55 then 0x0F, zero idle gap -> two oValid_rx pulses, data 0x55 then 0x0F, no errors.
//  6. Assert iRst during data bit 3 of 0xFF -> outputs at reset values, no pulse; next 0x3C received cleanly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (start, LSB-first data, optional parity, stop bits).
// Latency: oValid_rx pulses one clock after the mid-point sample of the last stop bit.
// Backpressure: none; oValid_rx is a one-cycle strobe and the word/flags hold until the next frame.
module uart_rx #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int BIT_LENGHT  = 8,
  parameter int PARITY_TYPE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iRx,
  output logic [BIT_LENGHT-1:0] oData_rx,
  output logic                  oValid_rx,
  output logic                  oBusy_rx,
  output logic                  oParity_err,
  output logic                  oFrame_err
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [3:0]       BIT_LAST  = 4'(BIT_LENGHT - 1);
  localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic                  rxMeta, rxS, rxPrev;
  logic [DIV_W-1:0]      divCnt;
  logic [3:0]            sampleCnt;
  logic [3:0]            bitCnt;
  logic [1:0]            stopCnt;
  logic [2:0]            state;
  logic [BIT_LENGHT-1:0] shiftReg;
  logic                  perr, ferr, doneP;
  logic                  osTick, startDet, sampleNow, expPar;

  assign osTick   = (divCnt == DIV_LAST);
  // Falling edge only: a line stuck low after a break cannot re-trigger until it has been seen high.
  assign startDet = (state == IDLE) && rxPrev && !rxS;
  // First sample lands mid start bit; later samples sit exactly one bit period apart.
  assign sampleNow = osTick && (sampleCnt == ((state == START) ? 4'd7 : 4'd15));
  assign expPar    = (PARITY_TYPE == 1) ? ~^shiftReg : ^shiftReg;

  // Two-flop synchroniser plus previous-value flop for start-edge detection; idles high.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= iRx;
      rxS    <= rxMeta;
      rxPrev <= rxS;
    end
  end

  // Oversampling divider, restarted on the start edge so ticks are phase-aligned to the frame.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      divCnt <= '0;
    end else if (startDet || osTick) begin
      divCnt <= '0;
    end else begin
      divCnt <= divCnt + 1'b1;
    end
  end

  // Tick counter: restarts after the mid start-bit sample so every later sample is at a 15->0 wrap.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      sampleCnt <= '0;
    end else if (startDet) begin
      sampleCnt <= '0;
    end else if (osTick) begin
      if (state == START && sampleCnt == 4'd7) begin
        sampleCnt <= '0;
      end else begin
        sampleCnt <= sampleCnt + 4'd1;
      end
    end
  end

  // Frame FSM: walks start, data, parity and stop bits, accumulating word and error flags.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state    <= IDLE;
      bitCnt   <= '0;
      stopCnt  <= '0;
      shiftReg <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      doneP    <= 1'b0;
    end else begin
      doneP <= 1'b0;
      case (state)
        IDLE: begin
          if (startDet) begin
            state   <= START;
            bitCnt  <= '0;
            stopCnt <= '0;
          end
        end
        START: begin
          if (sampleNow) begin
            if (rxS) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              perr  <= 1'b0;
              ferr  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (sampleNow) begin
            shiftReg <= {rxS, shiftReg[BIT_LENGHT-1:1]};
            if (bitCnt == BIT_LAST) begin
              bitCnt <= '0;
              state  <= (PARITY_TYPE != 0) ? PARITY : STOP;
            end else begin
              bitCnt <= bitCnt + 4'd1;
            end
          end
        end
        PARITY: begin
          if (sampleNow) begin
            perr  <= (rxS != expPar);
            state <= STOP;
          end
        end
        STOP: begin
          if (sampleNow) begin
            if (!rxS) begin
              ferr <= 1'b1;
            end
            // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
            if (stopCnt == STOP_LAST) begin
              state <= IDLE;
              doneP <= 1'b1;
            end else begin
              stopCnt <= stopCnt + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output registers: publish word and flags with the valid strobe; busy spans edge to completion.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oData_rx    <= '0;
      oValid_rx   <= 1'b0;
      oBusy_rx    <= 1'b0;
      oParity_err <= 1'b0;
      oFrame_err  <= 1'b0;
    end else begin
      oValid_rx <= doneP;
      if (doneP) begin
        oData_rx    <= shiftReg;
        oParity_err <= perr;
        oFrame_err  <= ferr;
      end
      if (startDet) begin
        oBusy_rx <= 1'b1;
      end else if (doneP || (state == START && sampleNow && rxS)) begin
        oBusy_rx <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: two receivers (8N1 and 8E2) fed by bench-driven serial lines, checked against a frame-level model.
module tb_uart_rx;

  localparam int CLK_FREQ = 800_000;
  localparam int BAUD     = 10_000;
  localparam int DIV      = CLK_FREQ / (BAUD * 16);
  localparam int BP       = 16 * DIV;

  logic iClk = 1'b0;
  logic iRst = 1'b0;
  logic rxA  = 1'b1;
  logic rxB  = 1'b1;

  logic [7:0] dataA, dataB;
  logic validA, busyA, perrA, ferrA;
  logic validB, busyB, perrB, ferrB;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .BIT_LENGHT(8), .PARITY_TYPE(0), .STOP_BITS(1)) dutA (
    .iClk(iClk), .iRst(iRst), .iRx(rxA), .oData_rx(dataA), .oValid_rx(validA),
    .oBusy_rx(busyA), .oParity_err(perrA), .oFrame_err(ferrA));

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .BIT_LENGHT(8), .PARITY_TYPE(2), .STOP_BITS(2)) dutB (
    .iClk(iClk), .iRst(iRst), .iRx(rxB), .oData_rx(dataB), .oValid_rx(validB),
    .oBusy_rx(busyB), .oParity_err(perrB), .oFrame_err(ferrB));

  always #5 iClk = ~iClk;

  int total = 0;
  int bad   = 0;
  int cyc;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         edgeCyc;
    int         lat;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];
  logic [7:0] lastD [2];
  logic       lastPe [2];
  logic       lastFe [2];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Frame-level expectation: parity error if the sent bit disagrees with even parity of the data,
  // framing error if any stop bit is low; result due half a bit into the last stop bit.
  task automatic pushExp(input int w, input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    int nb;
    nb = (w == 0) ? 10 : 12;
    e.d = d; e.pe = pe; e.fe = fe;
    e.edgeCyc = cyc;
    e.lat = BP / 2 + BP * (nb - 1);
    if (w == 0) qA.push_back(e); else qB.push_back(e);
  endtask

  task automatic cmpDut(input int w, input logic v, input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    int lat;
    if (v) begin
      if ((w == 0 && qA.size() == 0) || (w == 1 && qB.size() == 0)) begin
        chk($sformatf("spuriousValid%0d", w), 1, 0);
      end else begin
        if (w == 0) e = qA.pop_front(); else e = qB.pop_front();
        lat = cyc - e.edgeCyc;
        chk($sformatf("latencyInWindow%0d(lat=%0d)", w, lat), int'(lat >= e.lat && lat <= e.lat + 8), 1);
        lastD[w]  = e.d;
        lastPe[w] = e.pe;
        lastFe[w] = e.fe;
      end
    end
    chk($sformatf("heldOutputs%0d", w), int'({d, pe, fe}), int'({lastD[w], lastPe[w], lastFe[w]}));
  endtask

  // Compare process: reset values while in reset, otherwise valid strobes against the model queue.
  always @(negedge iClk) begin
    if (!iRst) begin
      chk("resetA", int'({dataA, validA, busyA, perrA, ferrA}), 0);
      chk("resetB", int'({dataB, validB, busyB, perrB, ferrB}), 0);
      for (int i = 0; i < 2; i++) begin
        lastD[i] = 8'h00; lastPe[i] = 1'b0; lastFe[i] = 1'b0;
      end
    end else begin
      cmpDut(0, validA, dataA, perrA, ferrA);
      cmpDut(1, validB, dataB, perrB, ferrB);
    end
  end

  task automatic drive(input int w, input logic b, input int ncyc);
    if (w == 0) rxA = b; else rxB = b;
    repeat (ncyc) @(posedge iClk);
    #1;
  endtask

  task automatic sendFrame(input int w, input logic [7:0] d, input logic parBit,
                           input logic s1, input logic s2, input int gapClk);
    pushExp(w, d, (w == 1) ? (parBit != ^d) : 1'b0, (w == 1) ? (!s1 || !s2) : !s1);
    drive(w, 1'b0, BP);
    for (int i = 0; i < 8; i++) drive(w, d[i], BP);
    if (w == 1) drive(w, parBit, BP);
    drive(w, s1, BP);
    if (w == 1) drive(w, s2, BP);
    if (gapClk > 0) drive(w, 1'b1, gapClk);
  endtask

  task automatic randLoop(input int w, input int n);
    logic [7:0] d;
    logic par, s1, s2, lastStop;
    int gap;
    for (int k = 0; k < n; k++) begin
      d   = 8'($urandom_range(0, 255));
      par = (^d) ^ ($urandom_range(0, 7) == 0);
      s1  = ($urandom_range(0, 9) != 0);
      s2  = ($urandom_range(0, 9) != 0);
      lastStop = (w == 1) ? s2 : s1;
      if (!lastStop) gap = BP + $urandom_range(0, BP);
      else if ($urandom_range(0, 2) == 0) gap = 0;
      else gap = $urandom_range(1, 2 * BP);
      sendFrame(w, d, par, s1, s2, gap);
    end
    drive(w, 1'b1, BP);
  endtask

  initial begin
    repeat (5) @(posedge iClk);
    #1;
    chk("rstDataA", int'(dataA), 0);
    chk("rstBusyA", int'(busyA), 0);
    iRst = 1'b1;
    drive(0, 1'b1, 2 * DIV);

    // Plain 8N1 word.
    sendFrame(0, 8'hA5, 1'b0, 1'b1, 1'b1, BP);
    chk("t1Data", int'(dataA), 'hA5);
    chk("t1Flags", int'({perrA, ferrA}), 0);
    chk("t1Busy", int'(busyA), 0);

    // Even parity: correct bit, then wrong bit.
    sendFrame(1, 8'h07, 1'b1, 1'b1, 1'b1, BP);
    chk("t2GoodPerr", int'(perrB), 0);
    sendFrame(1, 8'h07, 1'b0, 1'b1, 1'b1, BP);
    chk("t2BadData", int'(dataB), 'h07);
    chk("t2BadPerr", int'(perrB), 1);

    // Glitch shorter than half a bit: busy rises then drops, no strobe.
    drive(0, 1'b0, 2 * DIV);
    chk("t3BusyHigh", int'(busyA), 1);
    drive(0, 1'b0, 2 * DIV);
    drive(0, 1'b1, 12 * DIV);
    chk("t3BusyLow", int'(busyA), 0);

    // Framing error, then a clean frame clears the flags.
    sendFrame(0, 8'h3C, 1'b0, 1'b0, 1'b1, BP);
    chk("t4Data", int'(dataA), 'h3C);
    chk("t4Ferr", int'(ferrA), 1);
    sendFrame(0, 8'h11, 1'b0, 1'b1, 1'b1, BP);
    chk("t4CleanFlags", int'({dataA, perrA, ferrA}), 'h11 << 2);

    // Back-to-back frames with no idle gap.
    sendFrame(0, 8'h55, 1'b0, 1'b1, 1'b1, 0);
    sendFrame(0, 8'h0F, 1'b0, 1'b1, 1'b1, BP);
    chk("t5LastData", int'(dataA), 'h0F);

    // Reset in the middle of data bit 3 of 0xFF.
    drive(0, 1'b0, BP);
    for (int i = 0; i < 3; i++) drive(0, 1'b1, BP);
    drive(0, 1'b1, BP / 2);
    chk("t6BusyMid", int'(busyA), 1);
    iRst = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    chk("t6RstOut", int'({dataA, validA, busyA, perrA, ferrA}), 0);
    iRst = 1'b1;
    drive(0, 1'b1, BP);
    sendFrame(0, 8'h3C, 1'b0, 1'b1, 1'b1, BP);
    chk("t6After", int'({dataA, perrA, ferrA}), 'h3C << 2);

    // Break: line held low for many bit times yields one framing-error frame only.
    pushExp(0, 8'h00, 1'b0, 1'b1);
    drive(0, 1'b0, 20 * BP);
    drive(0, 1'b1, BP);
    chk("t7BreakFerr", int'({dataA, ferrA}), 1);
    chk("t7BreakBusy", int'(busyA), 0);

    // Random traffic on both links concurrently.
    fork
      randLoop(0, 30);
      randLoop(1, 30);
    join

    for (int i = 0; i < 4 * BP; i++) begin
      if (qA.size() == 0 && qB.size() == 0) break;
      @(posedge iClk);
    end
    chk("drainA", qA.size(), 0);
    chk("drainB", qB.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
